// File: rtl/fifo_packer.sv
// fifo_packer: pops narrow words from a first-word-fall-through FIFO and packs 2^RATIO_LOG of them per wide valid/ready beat.
// Define PACKER_FLUSH_EN to add the FLUSH input, which emits a partially filled beat.
module fifo_packer #(
    parameter int DATA_W    = 32,
    parameter int RATIO_LOG = 2
) (
    input  logic                           CLK,
    input  logic                           RST_X,
    input  logic                           FIFO_EMP,
    input  logic [DATA_W-1:0]              FIFO_DOT,
    output logic                           FIFO_DEQ,
    output logic [(DATA_W<<RATIO_LOG)-1:0] OUT_DATA,
    output logic [RATIO_LOG:0]             OUT_CNT,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                           FLUSH
`endif
);

    localparam int RATIO = 1 << RATIO_LOG;
    localparam int OUT_W = DATA_W * RATIO;
    localparam int CNT_W = RATIO_LOG + 1;
    localparam int IDX_W = (RATIO_LOG > 0) ? RATIO_LOG : 1;
    localparam int LANES = (RATIO > 1) ? RATIO - 1 : 1;

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] acc [LANES];

    logic              slot_free;
    logic              at_last;
    logic              deq;
    logic              complete;
    logic              fire;
    logic [OUT_W-1:0]  beat;
    logic [CNT_W-1:0]  beat_cnt;

    // The last lane goes straight into the output register, so only the
    // final pop of a beat has to wait for the output slot.
    always_comb begin
        slot_free = ~OUT_VALID | OUT_READY;
        at_last   = (idx == IDX_W'(RATIO - 1));
        deq       = RST_X & ~FIFO_EMP & (~at_last | slot_free);
        complete  = deq & at_last;
    end

    assign FIFO_DEQ = deq;

`ifdef PACKER_FLUSH_EN
    logic flush_pend;
    logic flush_fire;

    // A flush never produces an empty beat: it waits for at least one word.
    assign flush_fire = (flush_pend | FLUSH) & slot_free & ((idx != '0) | deq);
    assign fire       = complete | flush_fire;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            flush_pend <= 1'b0;
        end else if (fire) begin
            flush_pend <= 1'b0;
        end else if (FLUSH) begin
            flush_pend <= 1'b1;
        end
    end
`else
    assign fire = complete;
`endif

    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    always_comb begin
        beat = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (i < int'(idx)) begin
                beat[i*DATA_W +: DATA_W] = acc[i];
            end
        end
        if (deq) begin
            beat[int'(idx)*DATA_W +: DATA_W] = FIFO_DOT;
        end
        beat_cnt = CNT_W'(idx) + CNT_W'(deq);
    end

    // NOTE: the accumulator is a handful of flops, not a RAM, so it is reset like the rest of the state.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            idx       <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CNT   <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (fire) begin
                OUT_DATA  <= beat;
                OUT_CNT   <= beat_cnt;
                OUT_VALID <= 1'b1;
                idx       <= '0;
            end else begin
                if (OUT_READY) begin
                    OUT_VALID <= 1'b0;
                end
                if (deq) begin
                    idx <= idx + IDX_W'(1);
                end
            end
            for (int i = 0; i < LANES; i++) begin
                if (deq && !fire && (idx == IDX_W'(i))) begin
                    acc[i] <= FIFO_DOT;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_no_deq_on_empty: assert property (@(posedge CLK) disable iff (!RST_X)
        FIFO_EMP |-> !FIFO_DEQ);

    a_hold_under_backpressure: assert property (@(posedge CLK) disable iff (!RST_X)
        (OUT_VALID && !OUT_READY) |=> (OUT_VALID && $stable(OUT_DATA) && $stable(OUT_CNT)));

    a_no_empty_beat: assert property (@(posedge CLK) disable iff (!RST_X)
        OUT_VALID |-> (OUT_CNT != '0));

`ifndef PACKER_FLUSH_EN
    a_full_beats_only: assert property (@(posedge CLK) disable iff (!RST_X)
        OUT_VALID |-> (OUT_CNT == CNT_W'(RATIO)));
`endif
`endif

endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer: a queue-based FIFO model feeds the DUT, expected beats
// are formed from the pushed word stream, and a negedge monitor compares every accepted beat.
module tb_fifo_packer;

    localparam int DATA_W    = 32;
    localparam int RATIO_LOG = 2;
    localparam int RATIO     = 1 << RATIO_LOG;
    localparam int OUT_W     = DATA_W * RATIO;
    localparam int CNT_W     = RATIO_LOG + 1;

    logic              CLK       = 1'b0;
    logic              RST_X     = 1'b0;
    logic              FIFO_EMP  = 1'b1;
    logic [DATA_W-1:0] FIFO_DOT  = '0;
    logic              FIFO_DEQ;
    logic [OUT_W-1:0]  OUT_DATA;
    logic [CNT_W-1:0]  OUT_CNT;
    logic              OUT_VALID;
    logic              OUT_READY = 1'b0;
`ifdef PACKER_FLUSH_EN
    logic              FLUSH     = 1'b0;
    bit                flush_pend_m = 1'b0;
`endif

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [CNT_W-1:0] cnt;
    } beat_t;

    beat_t             exp_q [$];
    logic [DATA_W-1:0] fifo_q [$];
    logic [DATA_W-1:0] pending [$];
    beat_t             mon_b;
    int                checks = 0;
    int                errors = 0;
    bit                deq_s = 1'b0;
    bit                stall_prev = 1'b0;
    logic [OUT_W-1:0]  prev_data = '0;
    logic [CNT_W-1:0]  prev_cnt = '0;

    fifo_packer #(.DATA_W(DATA_W), .RATIO_LOG(RATIO_LOG)) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .FIFO_EMP  (FIFO_EMP),
        .FIFO_DOT  (FIFO_DOT),
        .FIFO_DEQ  (FIFO_DEQ),
        .OUT_DATA  (OUT_DATA),
        .OUT_CNT   (OUT_CNT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
`ifdef PACKER_FLUSH_EN
        ,
        .FLUSH     (FLUSH)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout_%s: condition not reached within its cycle budget", name);
    endtask

    // Expected beats: consecutive pushed words grouped RATIO at a time, first word in lane 0.
    function automatic void emit();
        beat_t b;
        b.data = '0;
        foreach (pending[i]) b.data[i*DATA_W +: DATA_W] = pending[i];
        b.cnt = CNT_W'(pending.size());
        exp_q.push_back(b);
        pending.delete();
`ifdef PACKER_FLUSH_EN
        flush_pend_m = 1'b0;
`endif
    endfunction

    task automatic push(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        pending.push_back(w);
`ifdef PACKER_FLUSH_EN
        if (pending.size() == RATIO || flush_pend_m) emit();
`else
        if (pending.size() == RATIO) emit();
`endif
    endtask

`ifdef PACKER_FLUSH_EN
    task automatic request_flush();
        if (pending.size() > 0) emit();
        else flush_pend_m = 1'b1;
    endtask
`endif

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (OUT_VALID) return;
        end
        timeout("valid");
    endtask

    task automatic wait_nonempty(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (!FIFO_EMP) return;
        end
        timeout("nonempty");
    endtask

    task automatic wait_fifo_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (fifo_q.size() == 0) return;
        end
        timeout("fifo_empty");
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0) begin
                step();
                return;
            end
        end
        timeout("drain");
    endtask

    // FIFO model: the head word is consumed at the edge following a negedge where FIFO_DEQ was high.
    always @(posedge CLK) begin
        #1;
        if (deq_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        FIFO_EMP = (fifo_q.size() == 0);
        FIFO_DOT = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    end

    // Monitor: inputs only change just after posedge, so the negedge view is what the next edge sees.
    always @(negedge CLK) begin
        deq_s = FIFO_DEQ;
        if (!RST_X) begin
            stall_prev = 1'b0;
        end else begin
            if (FIFO_EMP) check("deq_on_empty", FIFO_DEQ, 1'b0);
            if (stall_prev) begin
                check("hold_valid", OUT_VALID, 1'b1);
                check("hold_data", OUT_DATA, prev_data);
                check("hold_cnt", OUT_CNT, prev_cnt);
            end
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got %h cnt %0d, expected no beat", OUT_DATA, OUT_CNT);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat_data", OUT_DATA, mon_b.data);
                    check("beat_cnt", OUT_CNT, mon_b.cnt);
                end
            end
            stall_prev = OUT_VALID && !OUT_READY;
            prev_data  = OUT_DATA;
            prev_cnt   = OUT_CNT;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_valid", OUT_VALID, 1'b0);
        check("reset_data", OUT_DATA, '0);
        check("reset_cnt", OUT_CNT, '0);
        check("reset_deq", FIFO_DEQ, 1'b0);
        step();
        RST_X     = 1'b1;
        OUT_READY = 1'b1;

        // Streaming: eight words pop back to back, two full beats.
        for (int w = 1; w <= 8; w++) push(DATA_W'(w));
        wait_nonempty(10);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge CLK);
            check($sformatf("stream_deq_%0d", i), FIFO_DEQ, 1'b1);
        end
        wait_drain(50);

        // Backpressure: second beat fills to three words and stalls.
        OUT_READY = 1'b0;
        for (int w = 'h21; w <= 'h24; w++) push(DATA_W'(w));
        wait_valid(20);
        step();
        for (int w = 'h25; w <= 'h28; w++) push(DATA_W'(w));
        repeat (8) step();
        @(negedge CLK);
        check("stall_deq", FIFO_DEQ, 1'b0);
        check("stall_words_left", fifo_q.size(), 1);
        step();
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("release_deq", FIFO_DEQ, 1'b1);
        @(negedge CLK);
        check("no_gap_valid", OUT_VALID, 1'b1);
        wait_drain(50);

        // FIFO runs dry mid-fill.
        push('hA);
        push('hB);
        wait_fifo_empty(20);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("dry_valid", OUT_VALID, 1'b0);
        end
        step();
        push('hC);
        push('hD);
        wait_drain(50);

        // Asynchronous reset with a partial fill and an unaccepted beat.
        OUT_READY = 1'b0;
        for (int w = 'h30; w <= 'h35; w++) push(DATA_W'(w));
        wait_fifo_empty(30);
        step();
        #2;
        RST_X = 1'b0;
        exp_q.delete();
        pending.delete();
        #1;
        check("arst_valid", OUT_VALID, 1'b0);
        check("arst_data", OUT_DATA, '0);
        check("arst_cnt", OUT_CNT, '0);
        check("arst_deq", FIFO_DEQ, 1'b0);
        push('h10);
        step();
        step();
        @(negedge CLK);
        check("in_reset_deq", FIFO_DEQ, 1'b0);
        check("in_reset_words", fifo_q.size(), 1);
        step();
        RST_X     = 1'b1;
        OUT_READY = 1'b1;
        for (int w = 'h11; w <= 'h13; w++) push(DATA_W'(w));
        wait_drain(50);

`ifdef PACKER_FLUSH_EN
        // Partial beat on request, then a request that waits for a word.
        push('h5);
        push('h6);
        wait_fifo_empty(20);
        step();
        step();
        FLUSH = 1'b1;
        request_flush();
        step();
        FLUSH = 1'b0;
        wait_drain(50);
        FLUSH = 1'b1;
        request_flush();
        step();
        FLUSH = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("flush_empty_valid", OUT_VALID, 1'b0);
        end
        step();
        push('h7);
        wait_drain(50);
        for (int w = 'h41; w <= 'h44; w++) push(DATA_W'(w));
        wait_drain(50);
`endif

        // Random traffic with random backpressure.
        for (int i = 0; i < 500; i++) begin
            step();
            OUT_READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) push($urandom);
        end
        while ((pending.size() % RATIO) != 0) push($urandom);
        step();
        OUT_READY = 1'b1;
        wait_drain(2000);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_packer.md
Name: fifo_packer

Overview:
- Downstream consumer of the team's 32-bit FIFOs (block-RAM, distributed and SRL variants).
- Pops narrow words from one FIFO's read side and packs 2^RATIO_LOG consecutive words into one wide beat.
- Presents each wide beat on a valid/ready output toward wide consumers, such as a DRAM write path.
- Sustains one FIFO pop per cycle when the output side is not back-pressuring.

Parameters:
- DATA_W, 32: width of one FIFO word.
- RATIO_LOG, 2: log2 of the number of words per wide beat; 2 means 4 words and 128 bits.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_X  in  1  reset; asynchronous, active-low.
- FIFO_EMP  in  1  FIFO empty flag.
- FIFO_DOT  in  DATA_W  FIFO head word; first-word-fall-through, valid whenever FIFO_EMP=0.
- FIFO_DEQ  out  1  pop request to the FIFO; the head word is consumed at the edge where FIFO_DEQ=1.
- OUT_DATA  out  DATA_W<<RATIO_LOG  packed beat; the first-popped word occupies bits [DATA_W-1:0].
- OUT_CNT  out  RATIO_LOG+1  number of valid words in OUT_DATA.
- OUT_VALID  out  1  a beat is presented.
- OUT_READY  in  1  the consumer accepts the beat at the edge where OUT_VALID and OUT_READY are both 1.
- FLUSH  in  1  request to emit a partial beat; present only when PACKER_FLUSH_EN is defined.

Behaviour:
- Storage:
  - Accumulator of RATIO-1 word lanes, where RATIO=2^RATIO_LOG.
  - Fill index idx, range 0..RATIO-1.
  - A single output register holding OUT_DATA, OUT_CNT and OUT_VALID.
- Reset (RST_X=0, asynchronous):
  - idx=0, OUT_VALID=0, OUT_DATA=0, OUT_CNT=0, accumulator cleared.
  - FIFO_DEQ=0 while reset is asserted.
  - Reset mid-fill discards any partially packed words and any un-accepted beat.
- Output slot state:
  - slot_free = ~OUT_VALID | OUT_READY, i.e. the slot is empty or drains this cycle.
- Pop rule (combinational):
  - FIFO_DEQ = ~FIFO_EMP & ((idx != RATIO-1) | slot_free).
  - FIFO_DEQ never asserts while FIFO_EMP=1.
- Pop with idx < RATIO-1:
  - FIFO_DOT is written into lane idx.
  - idx increments.
- Pop with idx = RATIO-1:
  - OUT_DATA <= {FIFO_DOT, accumulator lanes RATIO-2..0}; OUT_CNT <= RATIO; OUT_VALID <= 1; idx <= 0.
- Latency: OUT_VALID rises at the same edge that pops the last word of the beat.
- Throughput: with OUT_READY held at 1, one word is popped per cycle and one beat is produced every RATIO cycles, with no bubbles.
- Backpressure:
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_CNT hold stable.
  - Filling continues up to idx=RATIO-1, then stalls.
- Beat accepted and no new beat completes in the same cycle: OUT_VALID <= 0 and OUT_DATA holds its old value.
- Beat accepted and a new beat completes in the same cycle: the new beat replaces the old one with no gap.
- FIFO_EMP toggling mid-fill: idx holds and no beat is emitted until the remaining words arrive.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- Defined:
  - Adds the FLUSH input and a 1-bit flush_pend register, reset to 0.
  - A FLUSH pulse sets flush_pend.
  - Flush fires at the first edge where flush_pend|FLUSH, slot_free, and (idx>0 or a pop occurs) all hold.
  - On firing, the beat contains the accumulated lanes plus the word popped that cycle, if any.
  - OUT_CNT = word count; unused upper lanes are 0.
  - On firing, idx <= 0 and flush_pend <= 0.
  - If idx reaches RATIO-1 with a pop in the firing cycle, the beat is a normal full beat and flush_pend clears.
  - FLUSH with idx=0 and no pop stays pending; no empty beat is ever emitted.
- Undefined:
  - No FLUSH port and no flush_pend register.
  - OUT_CNT is RATIO whenever OUT_VALID=1.

Test Plan:
- Reset, then enqueue 0x1..0x8 with OUT_READY=1 -> FIFO_DEQ high 8 consecutive cycles; beats 0x00000004_00000003_00000002_00000001 then 0x8_7_6_5 lane-packed; OUT_CNT=4.
- Fill 4 words with OUT_READY=0, then 4 more -> exactly 3 further pops; FIFO_DEQ=0 with idx=3 and the FIFO non-empty; OUT_DATA stable. Raise OUT_READY -> 4th pop at the same edge the first beat is accepted; the second beat follows with no gap.
- Push words 0xA, 0xB, then hold FIFO_EMP=1 for 10 cycles -> OUT_VALID stays 0 and idx=2. Push 0xC, 0xD -> one beat 0xD_C_B_A.
- Assert RST_X=0 asynchronously with idx=2 and OUT_VALID=1 -> OUT_VALID, OUT_DATA and FIFO_DEQ are 0 immediately. After release, words 0x10..0x13 produce beat 0x13_12_11_10.
- PACKER_FLUSH_EN: push 0x5, 0x6, pulse FLUSH -> beat 0x0_0_6_5 with OUT_CNT=2. FLUSH at idx=0 on an empty FIFO, then push 0x7 -> beat 0x0_0_0_7 with OUT_CNT=1.
